// File: rtl/universal_shift_reg_if.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_if
//
// Purpose:
//   Groups the data and select signals of the universal shift register into one
//   bundle. Clock and reset are not part of the bundle; they stay plain ports.
//
// Signals:
//   d    WIDTH  parallel load data (driven by master)
//   sel  2      operation select: 00 load, 01 shift left, 10 shift right, 11 hold
//   q    WIDTH  register contents (driven by slave)
//
// Modports:
//   master  drives d/sel, observes q (the user of the register)
//   slave   receives d/sel, drives q (the register itself)
// -----------------------------------------------------------------------------
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic [1:0]       sel;
    logic [WIDTH-1:0] q;

    modport master (
        output d,
        output sel,
        input  q
    );

    modport slave (
        input  d,
        input  sel,
        output q
    );
endinterface

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//
// Purpose:
//   Parameterised parallel-load / bidirectional shift register. On each rising
//   edge of clk the register is loaded, shifted left by one, shifted right by
//   one (logical), or held, as selected by bus.sel. q comes straight from the
//   register flops, so there is no combinational path from d/sel to q.
//
// Ports:
//   clk    in   1      clock, all updates on its rising edge
//   rst_n  in   1      synchronous active-low reset, clears the register and
//                      takes priority over every select value
//   bus    slave       d (load data), sel (operation), q (register contents)
//
// Parameters:
//   WIDTH  register / data width in bits (>= 2)
// -----------------------------------------------------------------------------
module universal_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    universal_shift_reg_if.slave bus
);

    localparam logic [1:0] SEL_LOAD  = 2'b00;
    localparam logic [1:0] SEL_SHL   = 2'b01;
    localparam logic [1:0] SEL_SHR   = 2'b10;
    localparam logic [1:0] SEL_HOLD  = 2'b11;

    logic [WIDTH-1:0] q_p0;

    // MSB falls off, zero enters at the LSB.
    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] val);
        return {val[WIDTH-2:0], 1'b0};
    endfunction

    // Logical shift: LSB falls off, zero enters at the MSB (no sign extension).
    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] val);
        return {1'b0, val[WIDTH-1:1]};
    endfunction

    // Stage p0: the single register stage; every operation has 1-cycle latency.
    // An unknown sel lands in the default branch and holds, so q never picks
    // up X from a bad select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_p0 <= '0;
        end else begin
            case (bus.sel)
                SEL_LOAD: q_p0 <= bus.d;
                SEL_SHL:  q_p0 <= shift_left(q_p0);
                SEL_SHR:  q_p0 <= shift_right(q_p0);
                SEL_HOLD: q_p0 <= q_p0;
                default:  q_p0 <= q_p0;
            endcase
        end
    end

    assign bus.q = q_p0;

endmodule

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Purpose:
//   Self-checking bench for universal_shift_reg at WIDTH=8: a table of
//   directed vectors, hand-written saturation sequences, and a randomized run
//   compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;

    localparam int WIDTH = 8;

    typedef struct {
        logic             rst_n;
        logic [1:0]       sel;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_q;
        string            name;
    } vec_t;

    logic clk;
    logic rst_n;

    universal_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: q=%h expected=%h", name, got, exp);
        end
    endtask

    // Apply inputs, let one rising edge sample them, then sample q 1 time unit later.
    task automatic step(input logic r, input logic [1:0] s, input logic [WIDTH-1:0] dv);
        rst_n   = r;
        bus.sel = s;
        bus.d   = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [1:0] s, input logic [WIDTH-1:0] dv,
                       input logic [WIDTH-1:0] e, input string n);
        vec_t v;
        v.rst_n = r;
        v.sel   = s;
        v.d     = dv;
        v.exp_q = e;
        v.name  = n;
        vecs.push_back(v);
    endtask

    // Reference model: register value as an integer, updated by arithmetic.
    function automatic int unsigned model_next(input int unsigned cur, input logic r,
                                               input logic [1:0] s, input int unsigned dv);
        int unsigned modulus;
        modulus = 1 << WIDTH;
        if (!r) return 0;
        case (s)
            2'b00:   return dv;
            2'b01:   return (cur * 2) % modulus;
            2'b10:   return cur / 2;
            default: return cur;
        endcase
    endfunction

    initial begin
        int unsigned mq;
        logic [WIDTH-1:0] expv;
        logic             r;
        logic [1:0]       s;
        logic [WIDTH-1:0] dv;

        rst_n   = 1'b0;
        bus.sel = 2'b00;
        bus.d   = 8'hFF;

        // Reset, then hold at zero
        add(0, 2'b00, 8'hFF, 8'h00, "reset0");
        add(0, 2'b00, 8'hFF, 8'h00, "reset1");
        for (int i = 0; i < 3; i++) add(1, 2'b11, 8'h5A, 8'h00, "hold_after_reset");
        // Load 03..07
        for (int i = 3; i <= 7; i++) add(1, 2'b00, 8'(i), 8'(i), "load");
        // Shift left with ignored d
        add(1, 2'b01, 8'h08, 8'h0E, "shl1");
        add(1, 2'b01, 8'h09, 8'h1C, "shl2");
        add(1, 2'b01, 8'h0A, 8'h38, "shl3");
        add(1, 2'b01, 8'h0B, 8'h70, "shl4");
        add(1, 2'b01, 8'h0C, 8'hE0, "shl5");
        // Shift right, zero fill
        add(1, 2'b00, 8'h0D, 8'h0D, "load_0d");
        add(1, 2'b10, 8'hFF, 8'h06, "shr1");
        add(1, 2'b10, 8'hFF, 8'h03, "shr2");
        add(1, 2'b10, 8'hFF, 8'h01, "shr3");
        add(1, 2'b10, 8'hFF, 8'h00, "shr4");
        add(1, 2'b10, 8'hFF, 8'h00, "shr5_zero");
        // Hold with changing d
        add(1, 2'b00, 8'hA5, 8'hA5, "load_a5");
        for (int i = 8'h0C; i <= 8'h10; i++) add(1, 2'b11, 8'(i), 8'hA5, "hold");
        // Reset mid-operation and release
        add(1, 2'b00, 8'h81, 8'h81, "load_81");
        add(1, 2'b01, 8'h00, 8'h02, "shl_81");
        add(0, 2'b00, 8'hFF, 8'h00, "mid_reset");
        add(1, 2'b00, 8'hFF, 8'hFF, "release_load");
        // Reset beats every select
        add(0, 2'b11, 8'h3C, 8'h00, "reset_over_hold");
        add(1, 2'b00, 8'h3C, 8'h3C, "load_3c");
        add(0, 2'b01, 8'h3C, 8'h00, "reset_over_shl");

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].sel, vecs[i].d);
            check(vecs[i].name, bus.q, vecs[i].exp_q);
        end

        // Right-shift saturation from the MSB
        step(1, 2'b00, 8'h80);
        check("sat_r_load", bus.q, 8'h80);
        for (int k = 1; k <= 8; k++) begin
            step(1, 2'b10, 8'($urandom));
            expv = 8'h80 >> k;
            check("sat_r", bus.q, expv);
        end
        step(1, 2'b10, 8'hFF);
        check("sat_r_stays0", bus.q, 8'h00);

        // Left-shift saturation from the LSB
        step(1, 2'b00, 8'h01);
        check("sat_l_load", bus.q, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            step(1, 2'b01, 8'($urandom));
            expv = 8'(9'h001 << k);
            check("sat_l", bus.q, expv);
        end
        step(1, 2'b01, 8'hFF);
        check("sat_l_stays0", bus.q, 8'h00);

        // Randomized run against the reference model
        mq = 32'(bus.q);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 15) != 0);
            s  = 2'($urandom_range(0, 3));
            dv = 8'($urandom);
            step(r, s, dv);
            mq = model_next(mq, r, s, 32'(dv));
            check("random", bus.q, 8'(mq));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
